// File: rtl/fifo_byte_packer.sv
// Drain stage for a synchronous byte FIFO: packs NB consecutive bytes (first byte
// in the low lane) into one word on a valid/ready output; flush emits a partial word.
module fifo_byte_packer #(
  parameter int NB = 4,
  parameter int CW = $clog2(NB + 1)
) (
  input  logic            CLK,
  input  logic            RSTn,
  input  logic            fifo_empty,
  input  logic [7:0]      fifo_data,
  output logic            fifo_read,
  input  logic            flush,
  input  logic            out_ready,
  output logic            out_valid,
  output logic [8*NB-1:0] out_data,
  output logic [CW-1:0]   out_nbytes,
  output logic            busy
);

  // Output handshake: a word transfers on a rising CLK edge where out_valid and
  // out_ready are both high; out_valid/out_data/out_nbytes hold until then.

  localparam logic [CW:0]   NB_WIDE = (CW + 1)'(NB);
  localparam logic [CW-1:0] NB_CNT  = CW'(NB);

  logic [8*NB-1:0] asm_q, asm_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            rd_pend_q;
  logic            flush_req_q, flush_req_d;
  logic            out_valid_d;
  logic [8*NB-1:0] out_data_d;
  logic [CW-1:0]   out_nbytes_d;

  logic [CW:0] fill;
  logic        out_free;
  logic        move_full;
  logic        flush_go;
  logic        move;

  always_comb begin
    fill      = {1'b0, cnt_q} + {{CW{1'b0}}, rd_pend_q};
    // A byte already in flight reserves its slot, so reads stop at NB total.
    fifo_read = RSTn && !fifo_empty && !flush_req_q && (fill < NB_WIDE);
    out_free  = !out_valid || out_ready;
    move_full = (cnt_q == NB_CNT) && out_free;
    flush_go  = flush_req_q && !rd_pend_q && out_free;
    move      = move_full || (flush_go && (cnt_q != '0));
    busy      = (cnt_q != '0) || rd_pend_q || flush_req_q || out_valid;
  end

  always_comb begin
    asm_d        = asm_q;
    cnt_d        = cnt_q;
    flush_req_d  = flush_req_q;
    out_valid_d  = out_valid;
    out_data_d   = out_data;
    out_nbytes_d = out_nbytes;

    if (out_valid && out_ready) out_valid_d = 1'b0;

    // Clearing the assembly on a move keeps unused upper lanes zero for partials.
    if (move) begin
      out_valid_d  = 1'b1;
      out_data_d   = asm_q;
      out_nbytes_d = cnt_q;
      asm_d        = '0;
      cnt_d        = '0;
    end

    if (rd_pend_q) begin
      for (int k = 0; k < NB; k++) begin
        if (cnt_d == CW'(k)) asm_d[8*k +: 8] = fifo_data;
      end
      cnt_d = cnt_d + CW'(1);
    end

    if (flush_go) flush_req_d = 1'b0;
    if (flush)    flush_req_d = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      asm_q       <= '0;
      cnt_q       <= '0;
      rd_pend_q   <= 1'b0;
      flush_req_q <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_nbytes  <= '0;
    end else begin
      asm_q       <= asm_d;
      cnt_q       <= cnt_d;
      rd_pend_q   <= fifo_read;
      flush_req_q <= flush_req_d;
      out_valid   <= out_valid_d;
      out_data    <= out_data_d;
      out_nbytes  <= out_nbytes_d;
    end
  end

endmodule

// File: tb/tb_fifo_byte_packer.sv
// Bench for fifo_byte_packer: a queue-based FIFO model feeds the DUT and a
// byte-grouping reference model predicts every output word.
module tb_fifo_byte_packer;

  localparam int NB = 4;
  localparam int CW = $clog2(NB + 1);

  logic            CLK = 1'b0;
  logic            RSTn;
  logic            fifo_empty;
  logic [7:0]      fifo_data;
  logic            fifo_read;
  logic            flush;
  logic            out_ready;
  logic            out_valid;
  logic [8*NB-1:0] out_data;
  logic [CW-1:0]   out_nbytes;
  logic            busy;

  int checks = 0;
  int errors = 0;
  int rd_count = 0;

  logic [8*NB-1:0] exp_q[$];
  logic [CW-1:0]   exp_nb_q[$];
  logic [7:0]      pend[$];
  logic [7:0]      fq[$];

  always #5 CLK = ~CLK;

  fifo_byte_packer #(.NB(NB)) dut (
    .CLK(CLK), .RSTn(RSTn), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_read(fifo_read), .flush(flush), .out_ready(out_ready),
    .out_valid(out_valid), .out_data(out_data), .out_nbytes(out_nbytes), .busy(busy)
  );

  // Reference model: every NB written bytes form one word, first byte lowest.
  task automatic push_byte(input logic [7:0] b);
    logic [8*NB-1:0] w;
    fq.push_back(b);
    fifo_empty = 1'b0;
    pend.push_back(b);
    if (pend.size() == NB) begin
      w = '0;
      for (int k = 0; k < NB; k++) w[8*k +: 8] = pend[k];
      exp_q.push_back(w);
      exp_nb_q.push_back(CW'(NB));
      pend.delete();
    end
  endtask

  task automatic model_flush();
    logic [8*NB-1:0] w;
    if (pend.size() > 0) begin
      w = '0;
      for (int k = 0; k < pend.size(); k++) w[8*k +: 8] = pend[k];
      exp_q.push_back(w);
      exp_nb_q.push_back(CW'(pend.size()));
      pend.delete();
    end
  endtask

  // One clock cycle: sample/score outputs mid-cycle, then advance the FIFO model.
  task automatic step();
    logic rd, rst;
    logic [8*NB-1:0] w;
    logic [CW-1:0]   n;
    #1;
    checks++;
    if (fifo_read === 1'b1 && fifo_empty === 1'b1) begin
      errors++;
      $display("FAIL underflow fifo_read=1 with fifo_empty=1 at %0t", $time);
    end
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_word got %h/%0d, none required at %0t", out_data, out_nbytes, $time);
      end else begin
        w = exp_q.pop_front();
        n = exp_nb_q.pop_front();
        if (out_data !== w || out_nbytes !== n) begin
          errors++;
          $display("FAIL word got %h/%0d required %h/%0d at %0t", out_data, out_nbytes, w, n, $time);
        end
      end
    end
    rd  = fifo_read;
    rst = RSTn;
    if (rd === 1'b1) rd_count++;
    @(posedge CLK);
    #1;
    if (!rst) begin
      fq.delete();
      fifo_data = '0;
    end else if (rd === 1'b1 && fq.size() > 0) begin
      fifo_data = fq.pop_front();
    end
    fifo_empty = (fq.size() == 0);
  endtask

  task automatic drain(input int budget, input string name);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout got %0d words outstanding required 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    RSTn = 1'b0; flush = 1'b0; out_ready = 1'b0; fifo_empty = 1'b1; fifo_data = '0;
    step(); step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b required 0", out_valid); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got %h required 0", out_data); end
    checks++; if (out_nbytes !== '0) begin errors++; $display("FAIL reset_out_nbytes got %0d required 0", out_nbytes); end
    checks++; if (fifo_read !== 1'b0) begin errors++; $display("FAIL reset_fifo_read got %b required 0", fifo_read); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b required 0", busy); end
    RSTn = 1'b1;
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy got %b required 0", busy); end
  endtask

  task automatic test_basic();
    int r0;
    r0 = rd_count;
    out_ready = 1'b1;
    for (int b = 1; b <= 8; b++) push_byte(8'(b));
    drain(60, "basic");
    repeat (3) step();
    checks++; if (rd_count - r0 != 8) begin errors++; $display("FAIL basic_reads got %0d required 8", rd_count - r0); end
    checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL basic_fifo_empty got %b required 1", fifo_empty); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy got %b required 0", busy); end
  endtask

  task automatic test_backpressure();
    int r0;
    logic seen, dropped;
    r0 = rd_count; seen = 1'b0; dropped = 1'b0;
    out_ready = 1'b0;
    for (int b = 0; b < 16; b++) push_byte(8'($urandom_range(0, 255)));
    for (int i = 0; i < 40; i++) begin
      step();
      if (out_valid === 1'b1) seen = 1'b1;
      else if (seen) dropped = 1'b1;
    end
    checks++; if (rd_count - r0 != 8) begin errors++; $display("FAIL bp_reads got %0d required 8", rd_count - r0); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid got %b required 1", out_valid); end
    checks++; if (dropped !== 1'b0) begin errors++; $display("FAIL bp_valid_held got drop=%b required 0", dropped); end
    out_ready = 1'b1;
    drain(80, "bp");
    repeat (3) step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_busy got %b required 0", busy); end
  endtask

  task automatic test_flush_partial();
    out_ready = 1'b1;
    push_byte(8'hAA); push_byte(8'hBB); push_byte(8'hCC);
    repeat (6) step();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL partial_busy_before got %b required 1", busy); end
    flush = 1'b1; model_flush();
    step();
    flush = 1'b0;
    drain(20, "partial");
    repeat (2) step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL partial_busy_after got %b required 0", busy); end
  endtask

  task automatic test_flush_empty();
    out_ready = 1'b1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL empty_flush_idle got busy=%b required 0", busy); end
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL empty_flush_req got busy=%b required 1", busy); end
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL empty_flush_clear got busy=%b required 0", busy); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL empty_flush_valid got %b required 0", out_valid); end
  endtask

  task automatic test_reset_midway();
    out_ready = 1'b1;
    for (int b = 0; b < 6; b++) push_byte(8'(8'h30 + b));
    repeat (3) step();
    RSTn = 1'b0;
    exp_q.delete(); exp_nb_q.delete(); pend.delete();
    step();
    RSTn = 1'b1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got %b required 0", out_valid); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL midrst_out_data got %h required 0", out_data); end
    checks++; if (out_nbytes !== '0) begin errors++; $display("FAIL midrst_out_nbytes got %0d required 0", out_nbytes); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b required 0", busy); end
    checks++; if (fifo_read !== 1'b0) begin errors++; $display("FAIL midrst_fifo_read got %b required 0", fifo_read); end
    repeat (10) step();
    for (int b = 0; b < 4; b++) push_byte(8'(8'h5A + b));
    drain(30, "midrst");
  endtask

  task automatic test_random();
    int pushed, cyc;
    pushed = 0; cyc = 0;
    while (pushed < 1000 && cyc < 20000) begin
      out_ready = ($urandom_range(0, 9) < 7);
      if (fq.size() < 16 && $urandom_range(0, 3) != 0) begin
        push_byte(8'($urandom_range(0, 255)));
        pushed++;
      end
      step();
      cyc++;
    end
    while (fq.size() != 0 && cyc < 20000) begin
      out_ready = ($urandom_range(0, 9) < 7);
      step();
      cyc++;
    end
    repeat (4) begin
      out_ready = ($urandom_range(0, 1) == 1);
      step();
    end
    flush = 1'b1; model_flush();
    step();
    flush = 1'b0;
    out_ready = 1'b1;
    drain(50, "random");
    repeat (3) step();
    checks++; if (pushed != 1000) begin errors++; $display("FAIL random_pushed got %0d required 1000", pushed); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL random_busy got %b required 0", busy); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_flush_partial();
    test_flush_empty();
    test_reset_midway();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
